// File: rtl/alu_bit_serial_ctrl_if.sv
// alu_bit_serial_ctrl_if: request/response and 1-bit slice signals of the bit-serial ALU sequencer.
interface alu_bit_serial_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       alu_op;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic [3:0]       slice_op;
  logic             slice_result;
  logic             slice_cout;
  modport slave (
    input  start, op_a, op_b, alu_op, slice_result, slice_cout,
    output busy, done, err, result, carry_out, overflow, zero, slice_a, slice_b, slice_cin, slice_op
  );
  modport master (
    output start, op_a, op_b, alu_op, slice_result, slice_cout,
    input  busy, done, err, result, carry_out, overflow, zero, slice_a, slice_b, slice_cin, slice_op
  );
endinterface

// File: rtl/alu_bit_serial_ctrl.sv
// alu_bit_serial_ctrl: sequences an external 1-bit ALU slice LSB first over WIDTH clocks.
module alu_bit_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  reset,
  alu_bit_serial_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, res_next;
  logic [3:0]       op_q, op_d;
  logic             carry_q, carry_d, co_q, co_d, ov_q, ov_d, zero_q, zero_d, err_q, err_d;
  logic             run, last, add_cls, accept, illegal;
  assign run     = state_q == RUN;
  assign last    = cnt_q == CW'(WIDTH - 1);
  assign add_cls = op_q[1:0] == 2'b10;
  assign accept  = state_q == IDLE && bus.start && bus.alu_op[1:0] != 2'b11;
  assign illegal = state_q == IDLE && bus.start && bus.alu_op[1:0] == 2'b11;
  always_comb begin
    res_next = result_q;
    res_next[cnt_q] = bus.slice_result;
  end
  always_comb begin
    state_d  = accept ? RUN : (run && last) ? DONE : (state_q == DONE) ? IDLE : state_q;
    cnt_d    = accept ? '0 : (run && !last) ? cnt_q + CW'(1) : cnt_q;
    a_d      = accept ? bus.op_a : a_q;
    b_d      = accept ? bus.op_b : b_q;
    op_d     = accept ? bus.alu_op : op_q;
    // Subtraction enters with carry 1 so ~b + 1 forms the two's complement.
    carry_d  = accept ? (bus.alu_op[1:0] == 2'b10 && bus.alu_op[2]) : (run && add_cls) ? bus.slice_cout : carry_q;
    result_d = run ? res_next : result_q;
    co_d     = (run && last) ? add_cls && bus.slice_cout : co_q;
    ov_d     = (run && last) ? add_cls && (carry_q ^ bus.slice_cout) : ov_q;
    zero_d   = (run && last) ? res_next == '0 : zero_q;
    err_d    = illegal;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
      ov_q     <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      co_q     <= co_d;
      ov_q     <= ov_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end
  assign bus.busy      = run;
  assign bus.done      = state_q == DONE;
  assign bus.err       = err_q;
  assign bus.result    = result_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ov_q;
  assign bus.zero      = zero_q;
  assign bus.slice_a   = run && a_q[cnt_q];
  assign bus.slice_b   = run && b_q[cnt_q];
  assign bus.slice_cin = run && carry_q;
  assign bus.slice_op  = run ? op_q : 4'b0000;
endmodule

// File: tb/tb_alu_bit_serial_ctrl.sv
// tb_alu_bit_serial_ctrl: scoreboard bench with a behavioural 1-bit ALU slice attached.
module tb_alu_bit_serial_ctrl;
  localparam int W = 8;
  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  alu_bit_serial_ctrl_if #(.WIDTH(W)) bus ();
  alu_bit_serial_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic sa, sb;
  assign sa = bus.slice_a ^ bus.slice_op[3];
  assign sb = bus.slice_b ^ bus.slice_op[2];
  assign bus.slice_result = bus.slice_op[1:0] == 2'b00 ? sa & sb :
                            bus.slice_op[1:0] == 2'b01 ? sa | sb : sa ^ sb ^ bus.slice_cin;
  assign bus.slice_cout = (sa & sb) | (sa & bus.slice_cin) | (sb & bus.slice_cin);
  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_res = '0;
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    logic [W:0] s;
    exp_t e;
    x = a ^ {W{op[3]}};
    y = b ^ {W{op[2]}};
    s = {1'b0, x} + {1'b0, y} + (W + 1)'(op[2]);
    e.r = op[1:0] == 2'b00 ? x & y : op[1:0] == 2'b01 ? x | y : s[W-1:0];
    e.c = op[1:0] == 2'b10 && s[W];
    e.v = op[1:0] == 2'b10 && x[W-1] == y[W-1] && s[W-1] != x[W-1];
    e.z = e.r == '0;
    return e;
  endfunction
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    bus.alu_op = op;
    bus.op_a = a;
    bus.op_b = b;
    bus.start = 1'b1;
    sb_q.push_back(model(op, a, b));
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
  endtask
  task automatic wait_done(input string nm);
    int cyc;
    exp_t e;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != W + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want %0d", nm, cyc, W + 1);
    end
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s done timeout", nm);
      return;
    end
    e = sb_q.pop_front();
    last_res = e.r;
    checks += 4;
    if (bus.result !== e.r) begin errors++; $display("FAIL %s result: got %h want %h", nm, bus.result, e.r); end
    if (bus.carry_out !== e.c) begin errors++; $display("FAIL %s carry_out: got %b want %b", nm, bus.carry_out, e.c); end
    if (bus.overflow !== e.v) begin errors++; $display("FAIL %s overflow: got %b want %b", nm, bus.overflow, e.v); end
    if (bus.zero !== e.z) begin errors++; $display("FAIL %s zero: got %b want %b", nm, bus.zero, e.z); end
    @(negedge clk);
    checks += 2;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done pulse: got %b want 0", nm, bus.done); end
    if (bus.result !== e.r) begin errors++; $display("FAIL %s result hold: got %h want %h", nm, bus.result, e.r); end
  endtask
  task automatic check_idle_zero(input string nm);
    checks += 9;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b want 0", nm, bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL %s done: got %b want 0", nm, bus.done); end
    if (bus.err !== 1'b0) begin errors++; $display("FAIL %s err: got %b want 0", nm, bus.err); end
    if (bus.result !== '0) begin errors++; $display("FAIL %s result: got %h want 00", nm, bus.result); end
    if (bus.carry_out !== 1'b0) begin errors++; $display("FAIL %s carry_out: got %b want 0", nm, bus.carry_out); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL %s overflow: got %b want 0", nm, bus.overflow); end
    if (bus.zero !== 1'b0) begin errors++; $display("FAIL %s zero: got %b want 0", nm, bus.zero); end
    if (bus.slice_op !== 4'b0000) begin errors++; $display("FAIL %s slice_op: got %b want 0000", nm, bus.slice_op); end
    if ({bus.slice_a, bus.slice_b, bus.slice_cin} !== 3'b000) begin
      errors++;
      $display("FAIL %s slice a/b/cin: got %b want 000", nm, {bus.slice_a, bus.slice_b, bus.slice_cin});
    end
  endtask
  task automatic test_reset();
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.alu_op = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_ops();
    issue(4'b0010, 8'h7F, 8'h01, 0); wait_done("add_7f_01");
    issue(4'b0110, 8'h05, 8'h05, 0); wait_done("sub_05_05");
    issue(4'b0110, 8'h03, 8'h05, 0); wait_done("sub_03_05");
    issue(4'b0000, 8'hF0, 8'h3C, 0); wait_done("and");
    issue(4'b0001, 8'hF0, 8'h3C, 0); wait_done("or");
    issue(4'b1100, 8'hF0, 8'h3C, 0); wait_done("nor");
    issue(4'b0010, 8'hFF, 8'h01, 0); wait_done("add_wrap");
  endtask
  task automatic test_illegal();
    bus.alu_op = 4'b0011;
    bus.op_a = 8'hAA;
    bus.op_b = 8'h55;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checks += 3;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL illegal err: got %b want 1", bus.err); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL illegal busy: got %b want 0", bus.busy); end
    if (bus.result !== last_res) begin errors++; $display("FAIL illegal result: got %h want %h", bus.result, last_res); end
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL illegal err pulse: got %b want 0", bus.err); end
  endtask
  task automatic test_hold_start();
    int dones;
    issue(4'b0010, 8'h12, 8'h34, 1);
    bus.op_a = 8'hFF;
    bus.op_b = 8'hFF;
    bus.alu_op = 4'b0001;
    wait_done("hold_start");
    bus.start = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL hold_start extra activity: got %0d cycles want 0", dones); end
  endtask
  task automatic test_reset_mid_run();
    int dones;
    issue(4'b0010, 8'h11, 8'h22, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    last_res = '0;
    check_idle_zero("reset_mid");
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL reset_mid done count: got %0d want 0", dones); end
    issue(4'b0010, 8'h40, 8'h40, 0); wait_done("add_after_reset");
  endtask
  task automatic test_back_to_back();
    issue(4'b0110, 8'h80, 8'h01, 0); wait_done("b2b_sub");
    issue(4'b0010, 8'h80, 8'h80, 0); wait_done("b2b_add");
    issue(4'b1101, 8'h0F, 8'h33, 0); wait_done("b2b_nand");
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard leftover: got %0d want 0", sb_q.size()); end
  endtask
  initial begin
    test_reset();
    test_ops();
    test_illegal();
    test_hold_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
